// File: rtl/figure_eight_step_gen.sv
// Step-pulse timing stage for the figure-eight animator: debounced speed buttons, rate divider, phase counter.
// Build option REVERSE_EN adds a dir input that makes step_count count down while dir=1.
module figure_eight_step_gen #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int BASE_SHIFT      = 4,
   parameter int RATE_MAX        = 7,
   parameter int RATE_RESET      = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_faster,
   input  logic       btn_slower,
   input  logic       pause,
   output logic       step,
   output logic [2:0] step_count,
   output logic [2:0] rate_idx
`ifdef REVERSE_EN
   ,
   input  logic       dir
`endif
);

   localparam int DIV_W = BASE_SHIFT + RATE_MAX;
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [2:0]       RATE_TOP  = 3'(RATE_MAX);
   localparam logic [2:0]       RATE_INIT = 3'(RATE_RESET);

   // bit 0 = faster, bit 1 = slower
   logic [1:0]       btn_raw;
   logic [1:0]       sync_a;
   logic [1:0]       sync_b;
   logic [1:0]       deb;
   logic [1:0]       deb_q;
   logic [1:0]       press;
   logic [CNT_W-1:0] db_cnt [2];

   logic             rate_up;
   logic             rate_dn;
   logic             rate_chg;
   logic [2:0]       rate_nxt;
   logic [2:0]       count_nxt;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] period_m1;

   assign btn_raw = {btn_slower, btn_faster};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_a <= '0;
         sync_b <= '0;
         deb    <= '0;
         deb_q  <= '0;
         press  <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
         deb_q  <= deb;
         press  <= deb & ~deb_q;
         for (int i = 0; i < 2; i++) begin
            if (sync_b[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= ~deb[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Simultaneous presses cancel; saturated presses are not a change.
   always_comb begin
      rate_up  = press[0] & ~press[1] & (rate_idx != RATE_TOP);
      rate_dn  = press[1] & ~press[0] & (rate_idx != 3'd0);
      rate_nxt = rate_idx;
      if (rate_up)
         rate_nxt = rate_idx + 3'd1;
      else if (rate_dn)
         rate_nxt = rate_idx - 3'd1;
   end

   assign rate_chg  = rate_up | rate_dn;
   // PERIOD-1 = 2^(DIV_W - rate_idx) - 1, i.e. all ones shifted down by the rate
   assign period_m1 = {DIV_W{1'b1}} >> rate_idx;

`ifdef REVERSE_EN
   assign count_nxt = dir ? (step_count - 3'd1) : (step_count + 3'd1);
`else
   assign count_nxt = step_count + 3'd1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rate_idx   <= RATE_INIT;
         div        <= '0;
         step       <= 1'b0;
         step_count <= '0;
      end else begin
         rate_idx <= rate_nxt;
         step     <= 1'b0;
         if (rate_chg) begin
            div <= '0;
         end else if (!pause) begin
            if (div == period_m1) begin
               div        <= '0;
               step       <= 1'b1;
               step_count <= count_nxt;
            end else begin
               div <= div + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_figure_eight_step_gen.sv
// Self-checking bench for figure_eight_step_gen: step timing, debounced rate control, pause and async reset.
`timescale 1ns/1ps
module tb_figure_eight_step_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_faster;
   logic       btn_slower;
   logic       pause;
   logic       step;
   logic [2:0] step_count;
   logic [2:0] rate_idx;
`ifdef REVERSE_EN
   logic       dir;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   figure_eight_step_gen dut (
      .clk        (clk),
      .reset      (reset),
      .btn_faster (btn_faster),
      .btn_slower (btn_slower),
      .pause      (pause),
      .step       (step),
      .step_count (step_count),
      .rate_idx   (rate_idx)
`ifdef REVERSE_EN
      ,
      .dir        (dir)
`endif
   );

   typedef struct {
      logic       faster;
      logic       slower;
      int         hold;
      logic [2:0] exp_rate;
      int         exp_period;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Edges until the next step pulse; gives up at 5000 so a dead divider shows as a wrong count.
   task automatic wait_step(output int cycles);
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
      end while (step !== 1'b1 && cycles < 5000);
   endtask

   task automatic press_btn(input logic f, input logic s, input int hold);
      btn_faster = f;
      btn_slower = s;
      tick(hold);
      btn_faster = 1'b0;
      btn_slower = 1'b0;
      tick(40);
   endtask

   initial begin
      int c;
      int nsteps;

      vecs[0]  = '{1'b1, 1'b0, 40, 3'd5, 64};
      vecs[1]  = '{1'b0, 1'b1, 10, 3'd5, 64};
      vecs[2]  = '{1'b1, 1'b1, 40, 3'd5, 64};
      vecs[3]  = '{1'b1, 1'b0, 40, 3'd6, 32};
      vecs[4]  = '{1'b1, 1'b0, 40, 3'd7, 16};
      vecs[5]  = '{1'b0, 1'b1, 40, 3'd6, 32};
      vecs[6]  = '{1'b0, 1'b1, 40, 3'd5, 64};
      vecs[7]  = '{1'b0, 1'b1, 40, 3'd4, 128};
      vecs[8]  = '{1'b0, 1'b1, 40, 3'd3, 256};
      vecs[9]  = '{1'b0, 1'b1, 40, 3'd2, 512};
      vecs[10] = '{1'b0, 1'b1, 40, 3'd1, 1024};
      vecs[11] = '{1'b0, 1'b1, 40, 3'd0, 2048};
      vecs[12] = '{1'b0, 1'b1, 40, 3'd0, 2048};

      reset      = 1'b1;
      btn_faster = 1'b0;
      btn_slower = 1'b0;
      pause      = 1'b0;
`ifdef REVERSE_EN
      dir        = 1'b0;
`endif
      tick(3);
      check("reset_step", {31'd0, step}, 32'd0);
      check("reset_step_count", {29'd0, step_count}, 32'd0);
      check("reset_rate", {29'd0, rate_idx}, 32'd3);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         wait_step(c);
         check("idle_period", c, 256);
         check("idle_step_count", {29'd0, step_count}, (i + 1) % 8);
      end
      tick(1);
      check("step_one_cycle", {31'd0, step}, 32'd0);

      wait_step(c);
      tick(100);
      pause  = 1'b1;
      nsteps = 0;
      repeat (50) begin
         tick(1);
         if (step === 1'b1) nsteps++;
      end
      pause = 1'b0;
      check("pause_no_step", nsteps, 0);
      wait_step(c);
      check("pause_resume_gap", c, 156);

      btn_faster = 1'b1;
      tick(19);
      check("press_rate_early", {29'd0, rate_idx}, 32'd3);
      tick(1);
      check("press_rate_update", {29'd0, rate_idx}, 32'd4);
      wait_step(c);
      check("period_from_clear", c, 128);
      btn_faster = 1'b0;
      tick(40);

      for (int i = 0; i < 5; i++) begin
         press_btn(vecs[i].faster, vecs[i].slower, vecs[i].hold);
         check($sformatf("vec%0d_rate", i), {29'd0, rate_idx}, {29'd0, vecs[i].exp_rate});
         wait_step(c);
         wait_step(c);
         check($sformatf("vec%0d_period", i), c, vecs[i].exp_period);
      end

      wait_step(c);
      btn_faster = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_step(c);
         check("saturated_press_gap", c, 16);
      end
      btn_faster = 1'b0;
      tick(40);
      check("saturated_rate", {29'd0, rate_idx}, 32'd7);

      for (int i = 5; i < 13; i++) begin
         press_btn(vecs[i].faster, vecs[i].slower, vecs[i].hold);
         check($sformatf("vec%0d_rate", i), {29'd0, rate_idx}, {29'd0, vecs[i].exp_rate});
         wait_step(c);
         wait_step(c);
         check($sformatf("vec%0d_period", i), c, vecs[i].exp_period);
      end

      for (int i = 0; i < 6; i++) press_btn(1'b1, 1'b0, 40);
      check("pre_reset_rate", {29'd0, rate_idx}, 32'd6);
      for (int i = 0; i < 16; i++) begin
         wait_step(c);
         if (step_count == 3'd5) break;
      end
      check("pre_reset_step_count", {29'd0, step_count}, 32'd5);
      tick(10);
      #3 reset = 1'b1;
      #1;
      check("async_reset_step", {31'd0, step}, 32'd0);
      check("async_reset_step_count", {29'd0, step_count}, 32'd0);
      check("async_reset_rate", {29'd0, rate_idx}, 32'd3);
      tick(2);
      reset = 1'b0;

`ifdef REVERSE_EN
      dir = 1'b1;
      wait_step(c);
      check("rev_count_a", {29'd0, step_count}, 32'd7);
      wait_step(c);
      check("rev_count_b", {29'd0, step_count}, 32'd6);
      dir = 1'b0;
      wait_step(c);
      check("fwd_count_a", {29'd0, step_count}, 32'd7);
      wait_step(c);
      check("fwd_count_b", {29'd0, step_count}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
